// File: rtl/soc_wb_pkg.sv
// Shared Wishbone definitions: initiator states, default widths, request/response payloads.
package soc_wb_pkg;

  localparam int unsigned WB_ADDR_W = 32;
  localparam int unsigned WB_DATA_W = 32;
  localparam int unsigned WB_SEL_W  = WB_DATA_W / 8;

  typedef enum logic [1:0] {
    WB_IDLE = 2'd0,
    WB_BUS  = 2'd1,
    WB_RESP = 2'd2
  } wb_init_state_e;

  typedef struct packed {
    logic                 we;
    logic [WB_ADDR_W-1:0] adr;
    logic [WB_DATA_W-1:0] dat;
    logic [WB_SEL_W-1:0]  sel;
  } wb_req_t;

  typedef struct packed {
    logic [WB_DATA_W-1:0] dat;
    logic                 err;
  } wb_rsp_t;

  // Bus phase terminates on error, acknowledge or timeout, whichever comes first.
  function automatic logic wb_bus_done(input logic ack, input logic err, input logic expired);
    return ack | err | expired;
  endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Cycle counter bounding the Wishbone bus phase; TIMEOUT = 0 disables it.
module wb_timeout_counter #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic expired
);

  generate
    if (TIMEOUT == 0) begin : g_off
      // No timeout: inputs deliberately unused, expiry never fires.
      logic unused_inputs;
      assign unused_inputs = clk_i ^ rst_i ^ clr ^ en;
      assign expired       = 1'b0;
    end else begin : g_on
      localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;

      // Clear has priority; otherwise count each enabled cycle.
      always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
          cnt_d = '0;
        end else if (en) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      // Counter register.
      always_ff @(posedge clk_i) begin
        if (rst_i) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end

      // Fires in the last allowed bus cycle so the phase lasts exactly TIMEOUT cycles.
      assign expired = en && (cnt_q == CNT_W'(TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/wb_initiator.sv
// Wishbone B4 classic single-transfer initiator with valid/ready request and response channels.
module wb_initiator
  import soc_wb_pkg::*;
#(
  parameter int unsigned ADDR_W  = WB_ADDR_W,
  parameter int unsigned DATA_W  = WB_DATA_W,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic                clk_i,
  input  logic                rst_i,
  // request channel
  input  logic                req_valid_i,
  output logic                req_ready_o,
  input  logic                req_we_i,
  input  logic [ADDR_W-1:0]   req_adr_i,
  input  logic [DATA_W-1:0]   req_dat_i,
  input  logic [DATA_W/8-1:0] req_sel_i,
  // response channel
  output logic                rsp_valid_o,
  input  logic                rsp_ready_i,
  output logic [DATA_W-1:0]   rsp_dat_o,
  output logic                rsp_err_o,
  // Wishbone initiator port
  output logic                wbm_cyc_o,
  output logic                wbm_stb_o,
  output logic                wbm_we_o,
  output logic [ADDR_W-1:0]   wbm_adr_o,
  output logic [DATA_W-1:0]   wbm_dat_o,
  output logic [DATA_W/8-1:0] wbm_sel_o,
  input  logic [DATA_W-1:0]   wbm_dat_i,
  input  logic                wbm_ack_i,
  input  logic                wbm_err_i
);

  localparam int unsigned SEL_W = DATA_W / 8;

  wb_init_state_e    state_q;
  logic              cyc_q;
  logic              stb_q;
  logic              we_q;
  logic [ADDR_W-1:0] adr_q;
  logic [DATA_W-1:0] wdat_q;
  logic [SEL_W-1:0]  sel_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_dat_q;
  logic              rsp_err_q;

  logic              req_hs;
  logic              in_bus;
  logic              expired;

  assign req_ready_o = (state_q == WB_IDLE);
  assign req_hs      = req_valid_i && req_ready_o;
  assign in_bus      = (state_q == WB_BUS);

  wb_timeout_counter #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clr     (req_hs),
    .en      (in_bus),
    .expired (expired)
  );

  // Transfer FSM: accept request, run one bus cycle, hold response until consumed.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= WB_IDLE;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      wdat_q      <= '0;
      sel_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        WB_IDLE: begin
          if (req_valid_i) begin
            we_q    <= req_we_i;
            adr_q   <= req_adr_i;
            wdat_q  <= req_dat_i;
            sel_q   <= req_sel_i;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            state_q <= WB_BUS;
          end
        end
        WB_BUS: begin
          if (wb_bus_done(wbm_ack_i, wbm_err_i, expired)) begin
            // Error beats acknowledge; timeout reports as an error with no data.
            if (wbm_err_i || !wbm_ack_i) begin
              rsp_err_q <= 1'b1;
              rsp_dat_q <= '0;
            end else begin
              rsp_err_q <= 1'b0;
              rsp_dat_q <= we_q ? '0 : wbm_dat_i;
            end
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            rsp_valid_q <= 1'b1;
            state_q     <= WB_RESP;
          end
        end
        WB_RESP: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= WB_IDLE;
          end
        end
        default: begin
          state_q <= WB_IDLE;
        end
      endcase
    end
  end

  assign wbm_cyc_o   = cyc_q;
  assign wbm_stb_o   = stb_q;
  assign wbm_we_o    = we_q;
  assign wbm_adr_o   = adr_q;
  assign wbm_dat_o   = wdat_q;
  assign wbm_sel_o   = sel_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_dat_o   = rsp_dat_q;
  assign rsp_err_o   = rsp_err_q;

endmodule
